// File: rtl/exec_control_core_pkg.sv
// Shared codes for the exec control core: optype, aluop, regsource,
// pcconfig, opcode/funct constants and the decoded control word.
package exec_control_core_pkg;

  typedef enum logic [1:0] {
    OPT_I = 2'd0,
    OPT_J = 2'd1,
    OPT_R = 2'd2
  } optype_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_BEQ   = 4'd11,
    ALU_BNE   = 4'd12
  } aluop_e;

  typedef enum logic [1:0] {
    REGSRC_ALU  = 2'd0,
    REGSRC_LOAD = 2'd1,
    REGSRC_PC   = 2'd2
  } regsrc_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_ABS = 2'd1,
    PC_REL = 2'd2
  } pccfg_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [1:0] optype;
    logic [2:0] deference;
    logic [3:0] aluop;
    logic [5:0] shamft;
    logic [1:0] pcconfig;
    logic       ramconfig;
    logic       regbankconfig;
    logic [1:0] regsource;
  } ctrl_t;

  function automatic logic [3:0] fn2alu(input logic [5:0] fn);
    unique case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      FN_SRA:  return ALU_SRA;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] op2alu(input logic [5:0] op);
    unique case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/exec_control_core_alu.sv
// 32-bit combinational ALU, wraparound arithmetic, no flags.
// Ports: a, b, c, aluop, shamft in; result out.
module alu_core
  import exec_control_core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [3:0]  aluop,
  input  logic [5:0]  shamft,
  output logic [31:0] result
);

  // 6-bit shift amounts >= 32 naturally flush to 0 (or sign fill).
  always_comb begin
    result = '0;
    unique case (aluop)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLL:   result = b << shamft;
      ALU_SRL:   result = b >> shamft;
      ALU_SRA:   result = $signed(b) >>> shamft;
      ALU_PASSA: result = a;
      ALU_BEQ:   result = (a == c) ? b : 32'd1;
      ALU_BNE:   result = (a != c) ? b : 32'd1;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/exec_control_core_clock_div.sv
// Divider: toggles clk_out every HALF_PERIOD input clocks.
// Ports: clk, rst_n in; clk_out out.
module clock_div_core #(
  parameter int unsigned HALF_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
);

  localparam logic [31:0] LIMIT = 32'(HALF_PERIOD - 1);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == LIMIT) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/exec_control_core.sv
// Clock divider, instruction decoder and ALU of the single-cycle core.
// MSB-first field bit 0 is bit 31 here; deference[0] (dest) is bit 2.
module exec_control_core
  import exec_control_core_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 25_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        clock_div,
  input  logic [31:0] instruction,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] opC,
  output logic [1:0]  optype,
  output logic [2:0]  deference,
  output logic [3:0]  aluop,
  output logic [5:0]  shamft,
  output logic [1:0]  pcconfig,
  output logic        ramconfig,
  output logic        regbankconfig,
  output logic [1:0]  regsource,
  output logic [31:0] result
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic       unused_fields;
  logic       is_r;
  logic       r_alu;
  logic       r_sh;
  logic       r_jr;
  logic       i_alu;
  ctrl_t      c;

  assign op            = instruction[31:26];
  assign shamt         = instruction[10:6];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:11];

  assign is_r  = op == OP_RTYPE;
  assign r_alu = is_r && (funct inside
    {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT});
  assign r_sh  = is_r && (funct inside {FN_SLL, FN_SRL, FN_SRA});
  assign r_jr  = is_r && (funct == FN_JR);
  assign i_alu = op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI};

  always_comb begin
    c        = '0;
    c.optype = OPT_R;
    unique case (1'b1)
      r_alu: begin
        c.deference     = 3'b011;
        c.aluop         = fn2alu(funct);
        c.regbankconfig = 1'b1;
      end
      r_sh: begin
        c.deference     = 3'b001;
        c.aluop         = fn2alu(funct);
        c.shamft        = {1'b0, shamt};
        c.regbankconfig = 1'b1;
      end
      r_jr: begin
        c.deference = 3'b010;
        c.aluop     = ALU_PASSA;
        c.pcconfig  = PC_ABS;
      end
      i_alu: begin
        c.optype        = OPT_I;
        c.deference     = 3'b010;
        c.aluop         = op2alu(op);
        c.regbankconfig = 1'b1;
      end
      (op == OP_LUI): begin
        c.optype        = OPT_I;
        c.aluop         = ALU_SLL;
        c.shamft        = 6'd16;
        c.regbankconfig = 1'b1;
      end
      (op == OP_LW): begin
        c.optype        = OPT_I;
        c.deference     = 3'b010;
        c.aluop         = ALU_ADD;
        c.regbankconfig = 1'b1;
        c.regsource     = REGSRC_LOAD;
      end
      (op == OP_SW): begin
        c.optype    = OPT_I;
        c.deference = 3'b110;
        c.aluop     = ALU_ADD;
        c.ramconfig = 1'b1;
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        c.optype    = OPT_I;
        c.deference = 3'b110;
        c.aluop     = (op == OP_BEQ) ? ALU_BEQ : ALU_BNE;
        c.pcconfig  = PC_REL;
      end
      (op == OP_J),
      (op == OP_JAL): begin
        c.optype   = OPT_J;
        c.aluop    = ALU_PASSA;
        c.pcconfig = PC_ABS;
        if (op == OP_JAL) begin
          c.regbankconfig = 1'b1;
          c.regsource     = REGSRC_PC;
        end
      end
      default: ;
    endcase
  end

  assign optype        = c.optype;
  assign deference     = c.deference;
  assign aluop         = c.aluop;
  assign shamft        = c.shamft;
  assign pcconfig      = c.pcconfig;
  assign ramconfig     = c.ramconfig;
  assign regbankconfig = c.regbankconfig;
  assign regsource     = c.regsource;

  clock_div_core #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_div (
    .clk    (clock),
    .rst_n  (reset_n),
    .clk_out(clock_div)
  );

  alu_core u_alu (
    .a     (opA),
    .b     (opB),
    .c     (opC),
    .aluop (c.aluop),
    .shamft(c.shamft),
    .result(result)
  );

endmodule

// File: tb/tb_exec_control_core.sv
// Directed bench for exec_control_core: divider, ALU, decoder.
// Second alu_core instance reaches shift amounts beyond 31.
module tb_exec_control_core;

  logic        clock;
  logic        reset_n;
  logic        clock_div;
  logic [31:0] instruction;
  logic [31:0] opA, opB, opC;
  logic [1:0]  optype;
  logic [2:0]  deference;
  logic [3:0]  aluop;
  logic [5:0]  shamft;
  logic [1:0]  pcconfig;
  logic        ramconfig;
  logic        regbankconfig;
  logic [1:0]  regsource;
  logic [31:0] result;

  logic [3:0]  x_op;
  logic [5:0]  x_sh;
  logic [31:0] x_res;

  int nchk = 0;
  int nerr = 0;

  exec_control_core #(.HALF_PERIOD(3)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clock_div    (clock_div),
    .instruction  (instruction),
    .opA          (opA),
    .opB          (opB),
    .opC          (opC),
    .optype       (optype),
    .deference    (deference),
    .aluop        (aluop),
    .shamft       (shamft),
    .pcconfig     (pcconfig),
    .ramconfig    (ramconfig),
    .regbankconfig(regbankconfig),
    .regsource    (regsource),
    .result       (result)
  );

  alu_core u_alu (
    .a     (opA),
    .b     (opB),
    .c     (opC),
    .aluop (x_op),
    .shamft(x_sh),
    .result(x_res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rins(input logic [5:0] fn,
                                       input logic [4:0] sa);
    return {6'h00, 15'h0, sa, fn};
  endfunction

  function automatic logic [31:0] iins(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  task automatic alu(input string tag, input logic [31:0] ins,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [31:0] exp);
    instruction = ins;
    opA = a;
    opB = b;
    opC = c;
    #1;
    chk(tag, result, exp);
  endtask

  logic [0:6] div_exp;

  initial begin
    reset_n     = 1'b0;
    instruction = '0;
    opA = '0;
    opB = '0;
    opC = '0;
    x_op = 4'd7;
    x_sh = 6'd0;
    div_exp = 7'b0011100;

    @(negedge clock);
    chk("div_reset", 32'(clock_div), 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      chk($sformatf("div_edge%0d", i + 1), 32'(clock_div),
          32'(div_exp[i]));
    end
    @(negedge clock);
    @(negedge clock);
    chk("div_high9", 32'(clock_div), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("div_async", 32'(clock_div), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    alu("add_wrap", rins(6'h20, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0,
        32'h0);
    alu("sub", rins(6'h22, 5'd0), 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE);
    alu("slt", rins(6'h2A, 5'd0), 32'h8000_0000, 32'h1, 32'h0, 32'h1);
    alu("slt_no", rins(6'h2A, 5'd0), 32'h1, 32'h8000_0000, 32'h0,
        32'h0);
    alu("nor", rins(6'h27, 5'd0), 32'hF0F0_0000, 32'h0000_000F, 32'h0,
        32'h0F0F_FFF0);
    alu("srl", rins(6'h02, 5'd4), 32'h0, 32'h8000_0000, 32'h0,
        32'h0800_0000);
    alu("sra", rins(6'h03, 5'd4), 32'h0, 32'h8000_0000, 32'h0,
        32'hF800_0000);
    alu("sll", rins(6'h00, 5'd4), 32'h0, 32'h8000_0001, 32'h0,
        32'h0000_0010);
    alu("lui", iins(6'h0F), 32'h0, 32'h0000_1234, 32'h0, 32'h1234_0000);
    alu("beq_t", iins(6'h04), 32'd9, 32'hFFFF_FFFC, 32'd9,
        32'hFFFF_FFFC);
    alu("beq_f", iins(6'h04), 32'd9, 32'hFFFF_FFFC, 32'd8, 32'h1);
    alu("bne_t", iins(6'h05), 32'd9, 32'hFFFF_FFFC, 32'd9, 32'h1);
    alu("bne_f", iins(6'h05), 32'd9, 32'hFFFF_FFFC, 32'd8,
        32'hFFFF_FFFC);
    alu("jr", rins(6'h08, 5'd0), 32'h0000_0ABC, 32'h5, 32'h0,
        32'h0000_0ABC);

    opB = 32'h8000_0000;
    x_op = 4'd7;
    x_sh = 6'd40;
    #1;
    chk("sll40", x_res, 32'h0);
    x_op = 4'd8;
    x_sh = 6'd32;
    #1;
    chk("srl32", x_res, 32'h0);
    x_op = 4'd9;
    x_sh = 6'd40;
    #1;
    chk("sra40", x_res, 32'hFFFF_FFFF);
    x_op = 4'd14;
    #1;
    chk("aluop14", x_res, 32'h0);

    instruction = rins(6'h20, 5'd0);
    #1;
    chk("add_optype", 32'(optype), 32'd2);
    chk("add_def", 32'(deference), 32'h3);
    chk("add_aluop", 32'(aluop), 32'd0);
    chk("add_rb", 32'(regbankconfig), 32'h1);
    chk("add_rsrc", 32'(regsource), 32'd0);
    chk("add_pc", 32'(pcconfig), 32'd0);

    instruction = rins(6'h03, 5'd7);
    #1;
    chk("sra_def", 32'(deference), 32'h1);
    chk("sra_sh", 32'(shamft), 32'd7);

    instruction = iins(6'h2B);
    #1;
    chk("sw_def", 32'(deference), 32'h6);
    chk("sw_ram", 32'(ramconfig), 32'h1);
    chk("sw_rb", 32'(regbankconfig), 32'h0);
    chk("sw_optype", 32'(optype), 32'd0);

    instruction = iins(6'h23);
    #1;
    chk("lw_rsrc", 32'(regsource), 32'd1);

    instruction = iins(6'h03);
    #1;
    chk("jal_optype", 32'(optype), 32'd1);
    chk("jal_pc", 32'(pcconfig), 32'd1);
    chk("jal_rb", 32'(regbankconfig), 32'h1);
    chk("jal_rsrc", 32'(regsource), 32'd2);

    instruction = iins(6'h04);
    #1;
    chk("beq_pc", 32'(pcconfig), 32'd2);

    instruction = iins(6'h3F);
    #1;
    chk("nop_ram", 32'(ramconfig), 32'h0);
    chk("nop_rb", 32'(regbankconfig), 32'h0);
    chk("nop_pc", 32'(pcconfig), 32'd0);
    chk("nop_optype", 32'(optype), 32'd2);
    chk("nop_aluop", 32'(aluop), 32'd0);

    instruction = rins(6'h3F, 5'd3);
    #1;
    chk("nopr_rb", 32'(regbankconfig), 32'h0);
    chk("nopr_sh", 32'(shamft), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/exec_control_core.md
Name: exec_control_core

Overview:
- Timing-and-control front end of the single-cycle processor, in one block.
- Parts: clock divider producing the processor clock, combinational instruction decoder (control word), combinational 32-bit ALU.
- Sits between program memory/register bank (instruction, operands in) and PC/RAM/register bank (result, control out).
- Bit vectors are MSB-first: [0:N-1], bit 0 is the MSB.

Parameters:
- HALF_PERIOD, 25_000_000, input-clock cycles per half period of clock_div (≥1).

Ports:
- clock  in  1  board clock.
- reset_n  in  1  asynchronous, active-low reset.
- clock_div  out  1  divided processor clock.
- instruction  in  32  current instruction.
- opA  in  32  ALU operand A.
- opB  in  32  ALU operand B.
- opC  in  32  ALU operand C, destination/compare value.
- optype  out  2  0 = I, 1 = J, 2 = R.
- deference  out  3  [0] dest, [1] opA, [2] opB; 1 = use register contents.
- aluop  out  4  ALU operation.
- shamft  out  6  shift amount.
- pcconfig  out  2  see Behaviour.
- ramconfig  out  1  RAM write enable.
- regbankconfig  out  1  register write enable.
- regsource  out  2  0 = ALU, 1 = RAM load, 2 = PC.
- result  out  32  ALU result.

Behaviour:

Divider:
- 32-bit counter on posedge clock.
- On reset_n = 0 (async): counter = 0, clock_div = 0.
- Otherwise, when counter == HALF_PERIOD-1: counter = 0 and clock_div toggles. Else counter increments.
- Period is 2*HALF_PERIOD input cycles.
- HALF_PERIOD = 1 gives clock/2.

Decoder:
- Purely combinational, zero latency, independent of reset.
- Fields: op = instruction[0:5], funct = [26:31], shamt = [21:25], zero-extended to 6 bits.
- R-type, op = 0x00; optype R; regbankconfig = 1; regsource ALU; pcconfig 00:
  - funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT: deference 011.
  - funct 0x00 SLL, 0x02 SRL, 0x03 SRA: deference 001, shamft = shamt.
  - funct 0x08 JR: deference 010, aluop PASSA, pcconfig 01, regbankconfig 0.
- I-type; optype I:
  - op 0x08 ADDI, 0x0A SLTI, 0x0C ANDI, 0x0D ORI, 0x0E XORI: deference 010, regbankconfig 1, source ALU.
  - op 0x0F LUI: aluop SLL, shamft 16, deference 000, regbankconfig 1.
  - op 0x23 LW: ADD, deference 010, regbankconfig 1, regsource LOAD.
  - op 0x2B SW: ADD, deference 110, ramconfig 1.
  - op 0x04 BEQ / 0x05 BNE: deference 110, aluop BEQ/BNE, pcconfig 10.
- J-type; optype J; deference 000; aluop PASSA; pcconfig 01:
  - op 0x02 J.
  - op 0x03 JAL: additionally regbankconfig 1, regsource PC.
- shamft = 0 unless stated.
- Any undefined op/funct is a NOP: all outputs 0, except optype R; ramconfig = 0 and regbankconfig = 0 guaranteed.

pcconfig semantics (consumed by the PC):
- 00: next = pc + 1.
- 01: next = result (absolute).
- 10: next = pc + result (relative).

ALU (combinational, 32-bit wraparound):
- 0 ADD: A+B.
- 1 SUB: A−B.
- 2 AND, 3 OR, 4 XOR: A op B.
- 5 NOR: ~(A|B).
- 6 SLT: signed A<B gives 1, else 0.
- 7 SLL: B<<shamft.
- 8 SRL: B>>shamft, logical.
- 9 SRA: B>>>shamft, arithmetic.
- 10 PASSA: A.
- 11 BEQ: (A==C) ? B : 1.
- 12 BNE: (A!=C) ? B : 1.
- 13–15: 0.
- shamft ≥ 32: SLL/SRL give 0; SRA gives 32 copies of B[0].
- No overflow flag.

Decomposition:
- Shared package holds: optype codes (I/J/R), aluop codes, regsource codes (REGSRC_ALU/LOAD/PC), pcconfig codes, opcode and funct constants.
- Sub-modules: clock_div_core (counter/toggle) and alu_core (operation mux). Decoder stays inline.

Test Plan:
- Divider: HALF_PERIOD = 3, reset_n pulsed low → clock_div low, then toggles every 3 clocks (period 6). Assert reset_n low mid-high phase → immediately 0.
- ALU arithmetic:
  - ADD 0xFFFFFFFF+1 → 0.
  - SUB 5−7 → 0xFFFFFFFE.
  - SLT A = 0x80000000, B = 1 → 1.
- ALU shifts, B = 0x80000000, shamft 4:
  - SRL → 0x08000000.
  - SRA → 0xF8000000.
  - SLL shamft 40 → 0.
- Branches, B = 0xFFFFFFFC:
  - BEQ, A = C = 9 → result 0xFFFFFFFC; A = 9, C = 8 → result 1.
  - BNE with the same operands gives the inverse.
- Decode:
  - ADD R-type (op 0, funct 0x20) → optype R, deference 011, aluop 0, regbankconfig 1, regsource 0, pcconfig 00.
  - SW (op 0x2B) → deference 110, ramconfig 1, regbankconfig 0.
  - JAL (op 0x03) → optype J, pcconfig 01, regbankconfig 1, regsource 2.
  - op 0x3F → all enables 0, pcconfig 00.
